// File: rtl/mod_exp_ctrl_if.sv
// Bus between the modular-exponentiation sequencer (master) and the Montgomery multiplier (slave).
// Handshake: the master holds mm_enable low for at least one cycle while the operands are stable,
// then raises it for the whole operation. The slave pulses mm_endflag for one cycle with mm_result
// valid, and the master drops mm_enable on the next edge. mm_endflag while mm_enable is low has no effect.
interface mod_exp_ctrl_if #(
    parameter int WIDTH = 256
);
    logic             mm_enable;
    logic [WIDTH-1:0] mm_modulos;
    logic [31:0]      mm_mp;
    logic [WIDTH-1:0] mm_multiplicand;
    logic [WIDTH-1:0] mm_indata;
    logic             mm_pow_bit;
    logic             mm_endflag;
    logic [WIDTH-1:0] mm_result;

    modport master (
        output mm_enable, mm_modulos, mm_mp, mm_multiplicand, mm_indata, mm_pow_bit,
        input  mm_endflag, mm_result
    );

    modport slave (
        input  mm_enable, mm_modulos, mm_mp, mm_multiplicand, mm_indata, mm_pow_bit,
        output mm_endflag, mm_result
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier, one MM op per bit.
// Optional MODEXP_LZ_SKIP_EN: SCAN walks past leading zero exponent bits before the first MM op.
module mod_exp_ctrl #(
    parameter int WIDTH       = 256,
    parameter int EXP_WIDTH   = 256,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_modulos,
    input  logic [31:0]          i_mp,
    input  logic [WIDTH-1:0]     i_base,
    input  logic [WIDTH-1:0]     i_one_mont,
    input  logic [EXP_WIDTH-1:0] i_exponent,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [WIDTH-1:0]     o_result,
    output logic [2:0]           o_state,
    mod_exp_ctrl_if.master       mm
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_NEXT = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mod;
    logic [31:0]          r_mp;
    logic [WIDTH-1:0]     r_base;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_mm_mult;
    logic                 r_mm_enable;
    logic                 r_mm_pow_bit;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;

    logic                 w_exp_zero;
    logic                 w_cur_bit;
    logic [IDX_W-1:0]     w_idx_dec;
    logic                 w_dec_bit;

    assign w_exp_zero = (r_exp == '0);
    assign w_cur_bit  = r_exp[r_idx];
    assign w_idx_dec  = r_idx - 1'b1;
    assign w_dec_bit  = r_exp[w_idx_dec];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= IDX_TOP;
            r_cnt        <= '0;
            r_exp        <= '0;
            r_acc        <= '0;
            r_mod        <= '0;
            r_mp         <= '0;
            r_base       <= '0;
            r_result     <= '0;
            r_mm_mult    <= '0;
            r_mm_enable  <= 1'b0;
            r_mm_pow_bit <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_exp   <= i_exponent;
                        r_mod   <= i_modulos;
                        r_mp    <= i_mp;
                        r_base  <= i_base;
                        r_acc   <= i_one_mont;
                        r_idx   <= IDX_TOP;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A zero exponent finishes with acc still equal to the Montgomery one.
                    if (w_exp_zero) begin
                        r_state <= S_FIN;
                    end
`ifdef MODEXP_LZ_SKIP_EN
                    else if (!w_cur_bit) begin
                        r_idx <= w_idx_dec;
                    end
`endif
                    else begin
                        r_mm_mult    <= r_acc;
                        r_mm_pow_bit <= w_cur_bit;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_mm_enable <= 1'b1;
                    r_cnt       <= '0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (mm.mm_endflag) begin
                        r_acc       <= mm.mm_result;
                        r_mm_enable <= 1'b0;
                        r_state     <= S_NEXT;
                    end else if (r_cnt == CNT_LAST) begin
                        r_mm_enable <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_idx == '0) begin
                        r_state <= S_FIN;
                    end else begin
                        r_idx        <= w_idx_dec;
                        r_mm_mult    <= r_acc;
                        r_mm_pow_bit <= w_dec_bit;
                        r_state      <= S_LOAD;
                    end
                end
                S_FIN: begin
                    r_result <= r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_err              = r_err;
    assign o_result           = r_result;
    assign o_state            = r_state;
    assign mm.mm_enable       = r_mm_enable;
    assign mm.mm_modulos      = r_mod;
    assign mm.mm_mp           = r_mp;
    assign mm.mm_multiplicand = r_mm_mult;
    assign mm.mm_indata       = r_base;
    assign mm.mm_pow_bit      = r_mm_pow_bit;

endmodule
